// File: rtl/fpu_pkg.sv
// Shared floating-point constants and FSM state encoding for the FPU divider and multiplier.
package fpu_pkg;

    localparam int FP_EXP_BITS = 8;
    localparam int FP_MAN_BITS = 23;

    function automatic int exp_bias(input int exp_bits);
        return (1 << (exp_bits - 1)) - 1;
    endfunction

    localparam int EXP_BIAS = exp_bias(FP_EXP_BITS);
    localparam int EXP_MIN  = 1;
    localparam int EXP_MAX  = (1 << FP_EXP_BITS) - 2;
    localparam int EXP_INF  = (1 << FP_EXP_BITS) - 1;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_DIVIDE,
        ST_ROUND,
        ST_DONE
    } fsm_state_e;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int WIDTH    = 24,
    parameter int CNT_BITS = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]    in_bits,
    output logic [CNT_BITS-1:0] count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CNT_BITS'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_bits[i]) count = CNT_BITS'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_div.sv
// Sequential IEEE-754 divider: restoring radix-2 mantissa division, round to nearest-even.
// Define FPU_DIV_FLAGS_EN to add flags[4:0] = {invalid, divzero, overflow, underflow, inexact}.
module fpu_div
    import fpu_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int MANTISSA_BITS = 23,
    parameter int EXPONENT_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out
`ifdef FPU_DIV_FLAGS_EN
    ,
    output logic [4:0]      flags
`endif
);

    localparam int M   = MANTISSA_BITS;
    localparam int E   = EXPONENT_BITS;
    localparam int EW  = E + 2;
    localparam int LZW = $clog2(M + 2);
    localparam int CW  = $clog2(M + 3);
    localparam int SHW = $clog2(M + 4);

    localparam bit IS_FP32  = (E == FP_EXP_BITS) && (M == FP_MAN_BITS);
    localparam int BIAS     = IS_FP32 ? EXP_BIAS : exp_bias(E);
    localparam int EXP_TOP  = IS_FP32 ? EXP_MAX : (1 << E) - 2;
    localparam int EXP_ONES = IS_FP32 ? EXP_INF : (1 << E) - 1;

    localparam logic signed [EW-1:0] BIAS_W    = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MIN_W = EW'(EXP_MIN);
    localparam logic signed [EW-1:0] EXP_TOP_W = EW'(EXP_TOP);
    localparam logic [E-1:0]         INF_EXP   = E'(EXP_ONES);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(M + 2);
    localparam logic [BITS-1:0]      NAN_P     = IS_FP32 ? BITS'(CANON_NAN)
                                               : {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    fsm_state_e            state_q, state_d;
    logic [BITS-1:0]       op_x_q, op_x_d, op_y_q, op_y_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [M:0]            div_q, div_d;
    logic [M+1:0]          rem_q, rem_d;
    logic [M+2:0]          quo_q, quo_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [BITS-1:0]       res_q, res_d;
`ifdef FPU_DIV_FLAGS_EN
    logic [4:0]            flg_q, flg_d;
`endif

    // Operand unpack and classification, consumed in NORM.
    logic                  x_sub, y_sub, x_is_nan, y_is_nan, x_is_inf, y_is_inf, x_is_zero, y_is_zero;
    logic [E-1:0]          x_exp_f, y_exp_f;
    logic [M:0]            x_raw, y_raw, x_man, y_man;
    logic [LZW-1:0]        x_lz, y_lz;
    logic signed [EW-1:0]  x_exp, y_exp;
    logic                  q_sign, special, res_nan, res_inf;
    logic [BITS-1:0]       spec_res;

    assign x_exp_f   = op_x_q[BITS-2:M];
    assign y_exp_f   = op_y_q[BITS-2:M];
    assign x_sub     = (x_exp_f == '0);
    assign y_sub     = (y_exp_f == '0);
    assign x_raw     = {~x_sub, op_x_q[M-1:0]};
    assign y_raw     = {~y_sub, op_y_q[M-1:0]};
    assign x_is_nan  = (x_exp_f == INF_EXP) && (op_x_q[M-1:0] != '0);
    assign y_is_nan  = (y_exp_f == INF_EXP) && (op_y_q[M-1:0] != '0);
    assign x_is_inf  = (x_exp_f == INF_EXP) && (op_x_q[M-1:0] == '0);
    assign y_is_inf  = (y_exp_f == INF_EXP) && (op_y_q[M-1:0] == '0);
    assign x_is_zero = x_sub && (op_x_q[M-1:0] == '0);
    assign y_is_zero = y_sub && (op_y_q[M-1:0] == '0);

    fpu_lzc #(.WIDTH(M + 1), .CNT_BITS(LZW)) u_lzc_x (.in_bits(x_raw), .count(x_lz));
    fpu_lzc #(.WIDTH(M + 1), .CNT_BITS(LZW)) u_lzc_y (.in_bits(y_raw), .count(y_lz));

    // Denormals are shifted until the hidden bit is set; their exponent goes below 1.
    assign x_man = x_raw << x_lz;
    assign y_man = y_raw << y_lz;
    assign x_exp = x_sub ? (EW'(1) - EW'(x_lz)) : EW'(x_exp_f);
    assign y_exp = y_sub ? (EW'(1) - EW'(y_lz)) : EW'(y_exp_f);

    assign q_sign   = op_x_q[BITS-1] ^ op_y_q[BITS-1];
    assign special  = x_is_nan | y_is_nan | x_is_inf | y_is_inf | x_is_zero | y_is_zero;
    assign res_nan  = x_is_nan | y_is_nan | (x_is_zero & y_is_zero) | (x_is_inf & y_is_inf);
    assign res_inf  = x_is_inf | y_is_zero;
    assign spec_res = res_nan ? NAN_P
                    : res_inf ? {q_sign, INF_EXP, {M{1'b0}}}
                    : {q_sign, {(BITS-1){1'b0}}};

    // One restoring step: subtract when the partial remainder covers the divisor.
    logic         step_ge;
    logic [M+1:0] rem_sub;
    assign step_ge = (rem_q >= {1'b0, div_q});
    assign rem_sub = step_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    // Normalize, optionally denormalize, then round to nearest-even.
    logic signed [EW-1:0] rnd_exp_n, rnd_exp_f;
    logic [EW-1:0]        rnd_shamt;
    logic [SHW-1:0]       rnd_sh;
    logic [M+2:0]         rnd_man_n, rnd_shifted;
    logic [M:0]           rnd_mant;
    logic [M+1:0]         rnd_sum;
    logic [M-1:0]         rnd_frac;
    logic                 rnd_tiny, rnd_lost, rnd_guard, rnd_sticky, rnd_up, rnd_ovf;
    logic [BITS-1:0]      rnd_res;

    // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        rnd_exp_n   = quo_q[M+2] ? exp_q : (exp_q - EW'(1));
        rnd_man_n   = quo_q[M+2] ? quo_q : {quo_q[M+1:0], 1'b0};
        rnd_tiny    = (rnd_exp_n < EXP_MIN_W);
        rnd_shamt   = EXP_MIN_W - rnd_exp_n;
        rnd_sh      = '0;
        if (rnd_tiny) rnd_sh = (rnd_shamt > EW'(M + 3)) ? SHW'(M + 3) : rnd_shamt[SHW-1:0];
        rnd_shifted = rnd_man_n >> rnd_sh;
        rnd_lost    = |(rnd_man_n & ~({(M+3){1'b1}} << rnd_sh));
        rnd_mant    = rnd_shifted[M+2:2];
        rnd_guard   = rnd_shifted[1];
        rnd_sticky  = rnd_shifted[0] | rnd_lost | (rem_q != '0);
        rnd_up      = rnd_guard & (rnd_sticky | rnd_mant[0]);
        rnd_sum     = {1'b0, rnd_mant} + {{(M+1){1'b0}}, rnd_up};
        rnd_exp_f   = rnd_tiny ? '0 : rnd_exp_n;
        rnd_frac    = rnd_sum[M-1:0];
        if (rnd_sum[M+1]) begin
            rnd_exp_f = rnd_exp_f + EW'(1);
            rnd_frac  = rnd_sum[M:1];
        end else if (rnd_tiny && rnd_sum[M]) begin
            rnd_exp_f = EW'(1);
        end
        rnd_ovf = !rnd_tiny && (rnd_exp_f > EXP_TOP_W);
        rnd_res = rnd_ovf ? {sign_q, INF_EXP, {M{1'b0}}} : {sign_q, rnd_exp_f[E-1:0], rnd_frac};
    end

    always_comb begin
        state_d = state_q;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef FPU_DIV_FLAGS_EN
        flg_d   = flg_q;
`endif
        // out_valid rises one cycle after DONE is entered and drops on the handshake.
        out_valid_d = (state_q == ST_DONE) && !(out_valid_q && out_ready);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_x_d  = x;
                    op_y_d  = y;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                sign_d = q_sign;
                exp_d  = x_exp - y_exp + BIAS_W;
                div_d  = y_man;
                rem_d  = {1'b0, x_man};
                quo_d  = '0;
                cnt_d  = '0;
                if (special) begin
                    res_d   = spec_res;
                    state_d = ST_DONE;
`ifdef FPU_DIV_FLAGS_EN
                    flg_d = {(x_is_zero & y_is_zero) | (x_is_inf & y_is_inf)
                                 | (x_is_nan & ~op_x_q[M-1]) | (y_is_nan & ~op_y_q[M-1]),
                             y_is_zero & ~(x_is_nan | x_is_inf | x_is_zero),
                             3'b000};
`endif
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[M+1:0], step_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                res_d   = rnd_res;
                state_d = ST_DONE;
`ifdef FPU_DIV_FLAGS_EN
                flg_d = {2'b00, rnd_ovf,
                         rnd_tiny & (rnd_guard | rnd_sticky),
                         rnd_guard | rnd_sticky | rnd_ovf};
`endif
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    // NOTE: datapath registers carry no reset; each is loaded in IDLE or NORM before it is read.
    always_ff @(posedge clk) begin
        op_x_q <= op_x_d;
        op_y_q <= op_y_d;
        sign_q <= sign_d;
        exp_q  <= exp_d;
        div_q  <= div_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= cnt_d;
    end

`ifdef FPU_DIV_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) flg_q <= '0;
        else     flg_q <= flg_d;
    end
    assign flags = flg_q;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out       = res_q;

endmodule

// File: doc/fpu_div.md
FPU_DIV -- requirements
Module: fpu_div

Interface
REQ-001 SHALL have parameter BITS, default 32, total word width.
REQ-002 SHALL have parameter MANTISSA_BITS, default 23, stored fraction width.
REQ-003 SHALL have parameter EXPONENT_BITS, default 8, exponent width.
- BITS SHALL equal MANTISSA_BITS+EXPONENT_BITS+1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, operands present.
REQ-007 SHALL have port in_ready, output, 1, block can accept operands.
REQ-008 SHALL have port x, input, BITS, IEEE-754 dividend.
REQ-009 SHALL have port y, input, BITS, IEEE-754 divisor.
REQ-010 SHALL have port out_valid, output, 1, quotient present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes quotient.
REQ-012 SHALL have port out, output, BITS, IEEE-754 quotient x/y.

Function
REQ-013 SHALL run the FSM IDLE -> NORM -> DIVIDE -> ROUND -> DONE -> IDLE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and SHALL capture x,y on the edge where in_valid&&in_ready.
REQ-015 SHALL spend one cycle in NORM, where it unpacks operands, sets the hidden bit, left-normalizes denormal mantissas with adjusted exponents, and classifies specials.
REQ-016 SHALL jump from NORM directly to DONE for specials, giving out_valid 2 cycles after acceptance.
- Any NaN -> 0x7FC00000 (sign 0, exponent all ones, fraction MSB 1).
- 0/0 -> NaN; inf/inf -> NaN.
- inf/finite -> inf, sign xS^yS.
- finite nonzero/0 -> inf, sign xS^yS.
- finite/inf -> zero, sign xS^yS.
- 0/finite nonzero -> zero, sign xS^yS.
REQ-017 SHALL perform restoring radix-2 division in DIVIDE for exactly MANTISSA_BITS+3 cycles, producing one quotient bit per cycle (mantissa, guard, round), with sticky = nonzero final remainder.
REQ-018 SHALL compute the exponent as xE-yE+bias in EXPONENT_BITS+2 signed bits, and SHALL left-shift the quotient by 1 with exponent-1 when its MSB is 0.
REQ-019 SHALL, in ROUND (1 cycle), right-shift into denormal range when exponent<1, folding shifted-out bits into sticky, then round to nearest-even.
- Mantissa carry SHALL increment the exponent.
- Exponent >= all-ones SHALL give inf.
- A zero result SHALL keep sign xS^yS.
REQ-020 SHALL make finite-operand latency exactly MANTISSA_BITS+6 cycles from the acceptance edge to the first out_valid cycle (29 at default).
REQ-021 SHALL hold out_valid=1 and out stable in DONE until out_ready=1, then go to IDLE; in_ready SHALL assert the following cycle (no same-cycle accept).
REQ-022 SHALL ignore in_valid outside IDLE, and SHALL ignore out_ready when out_valid=0.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, enter IDLE with in_ready=1, out_valid=0, and out=0.
REQ-024 SHALL, when rst is asserted mid-operation (any state), discard the operation with no output produced.

Configuration
REQ-025 SHALL, with macro FPU_DIV_FLAGS_EN defined, add output port flags[4:0] = {invalid, divzero, overflow, underflow, inexact}.
- flags SHALL be valid with out_valid and 0 at reset.
- underflow SHALL be set when the result is tiny and inexact.
- Without FPU_DIV_FLAGS_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 SHALL take from package fpu_pkg the bias/min/max/inf exponent localparams, the canonical NaN constant, and the FSM state enum, shared with the multiplier.
REQ-027 SHALL instantiate one sub-module, fpu_lzc (leading-zero counter), for denormal normalization in NORM.

Verification
REQ-028 SHALL cover: 0x40C00000/0x40000000 -> 0x40400000, out_valid exactly 29 cycles after accept.
REQ-029 SHALL cover: 0x3F800000/0x40400000 -> 0x3EAAAAAB (round up), flags inexact only.
REQ-030 SHALL cover: 0x3F800000/0x00000000 -> 0x7F800000, divzero; 0x00000000/0x00000000 -> 0x7FC00000, invalid; both out_valid 2 cycles after accept.
REQ-031 SHALL cover: 0x00000001/0x40000000 -> 0x00000000 (tie to even), underflow+inexact; 0x7F7FFFFF/0x3F000000 -> 0x7F800000, overflow+inexact.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out and out_valid stable, in_ready 0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-033 SHALL cover: rst pulsed during DIVIDE cycle 10 -> IDLE next cycle, out_valid never asserts; a new operation completes correctly.
